// File: rtl/stdp_sched_if.sv
// Handshake bundle between the timestep controller, the STDP scheduler and the STDP engine.
// The master drives the i_* side; the scheduler (slave) drives the o_* side.
interface stdp_sched_if #(
  parameter int NUM_POST = 18,
  parameter int NUM_PRE  = 24
);
  logic                i_learn_en;
  logic                i_step;
  logic [NUM_POST-1:0] i_post_spike;
  logic [NUM_PRE-1:0]  i_pre_spike;
  logic                i_stdp_done;
  logic                i_clr_err;
  logic                o_stdp_run;
  logic                o_stdp_sub;
  logic [NUM_POST-1:0] o_post_spike;
  logic [NUM_PRE-1:0]  o_pre_spike;
  logic                o_trace_hold;
  logic                o_busy;
  logic                o_step_done;
  logic [15:0]         o_run_cnt;
  logic [15:0]         o_skip_cnt;
  logic                o_timeout_err;
  logic                o_overrun;

  modport master (
    output i_learn_en, i_step, i_post_spike, i_pre_spike, i_stdp_done, i_clr_err,
    input  o_stdp_run, o_stdp_sub, o_post_spike, o_pre_spike, o_trace_hold, o_busy,
           o_step_done, o_run_cnt, o_skip_cnt, o_timeout_err, o_overrun
  );

  modport slave (
    input  i_learn_en, i_step, i_post_spike, i_pre_spike, i_stdp_done, i_clr_err,
    output o_stdp_run, o_stdp_sub, o_post_spike, o_pre_spike, o_trace_hold, o_busy,
           o_step_done, o_run_cnt, o_skip_cnt, o_timeout_err, o_overrun
  );
endinterface

// File: rtl/stdp_sched.sv
// Per-timestep STDP scheduler: latches spikes on i_step, decides run/skip, pulses the engine, waits for done.
// Latency: run at step+2, step_done at step+2 (skip) or done+1 / first WAIT+TIMEOUT; steps while busy are dropped.
module stdp_sched #(
  parameter int SUB_PERIOD = 16,
  parameter int TIMEOUT    = 1023,
  parameter int NUM_POST   = 18,
  parameter int NUM_PRE    = 24
) (
  input  logic         clk,
  input  logic         reset,
  stdp_sched_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECIDE = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [15:0] SUB_LAST = 16'(SUB_PERIOD - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  logic [2:0]          state_q,    state_d;
  logic [NUM_POST-1:0] post_q,     post_d;
  logic [NUM_PRE-1:0]  pre_q,      pre_d;
  logic                learn_en_q, learn_en_d;
  logic                sub_due_q,  sub_due_d;
  logic                sub_q,      sub_d;
  logic [15:0]         sub_cnt_q,  sub_cnt_d;
  logic [15:0]         timer_q,    timer_d;
  logic [15:0]         run_cnt_q,  run_cnt_d;
  logic [15:0]         skip_cnt_q, skip_cnt_d;
  logic                tmo_err_q,  tmo_err_d;
  logic                overrun_q,  overrun_d;
  logic                tmo_set;
  logic                overrun_set;

  always_comb begin
    state_d    = state_q;
    post_d     = post_q;
    pre_d      = pre_q;
    learn_en_d = learn_en_q;
    sub_due_d  = sub_due_q;
    sub_d      = sub_q;
    sub_cnt_d  = sub_cnt_q;
    timer_d    = timer_q;
    run_cnt_d  = run_cnt_q;
    skip_cnt_d = skip_cnt_q;
    tmo_set    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_step) begin
          post_d     = bus.i_post_spike;
          pre_d      = bus.i_pre_spike;
          learn_en_d = bus.i_learn_en;
          sub_due_d  = (sub_cnt_q == SUB_LAST);
          state_d    = S_DECIDE;
        end
      end
      S_DECIDE: begin
        // A due decrement pass forces a run even with no spikes.
        if (learn_en_q && ((|post_q) || (|pre_q) || sub_due_q)) begin
          sub_d   = sub_due_q;
          state_d = S_RUN;
        end else begin
          if (skip_cnt_q != CNT_MAX) skip_cnt_d = skip_cnt_q + 16'd1;
          state_d = S_FINISH;
        end
      end
      S_RUN: begin
        if (run_cnt_q != CNT_MAX) run_cnt_d = run_cnt_q + 16'd1;
        timer_d = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 16'd1;
        if (bus.i_stdp_done) begin
          sub_d   = 1'b0;
          state_d = S_FINISH;
        end else if (timer_q == TMO_LAST) begin
          tmo_set = 1'b1;
          sub_d   = 1'b0;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        if (learn_en_q) sub_cnt_d = sub_due_q ? 16'd0 : sub_cnt_q + 16'd1;
        sub_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    overrun_set = bus.i_step && (state_q != S_IDLE);
    // A new error event beats a simultaneous clear.
    tmo_err_d = tmo_set     ? 1'b1 : (bus.i_clr_err ? 1'b0 : tmo_err_q);
    overrun_d = overrun_set ? 1'b1 : (bus.i_clr_err ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      post_q     <= '0;
      pre_q      <= '0;
      learn_en_q <= 1'b0;
      sub_due_q  <= 1'b0;
      sub_q      <= 1'b0;
      sub_cnt_q  <= 16'd0;
      timer_q    <= 16'd0;
      run_cnt_q  <= 16'd0;
      skip_cnt_q <= 16'd0;
      tmo_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      post_q     <= post_d;
      pre_q      <= pre_d;
      learn_en_q <= learn_en_d;
      sub_due_q  <= sub_due_d;
      sub_q      <= sub_d;
      sub_cnt_q  <= sub_cnt_d;
      timer_q    <= timer_d;
      run_cnt_q  <= run_cnt_d;
      skip_cnt_q <= skip_cnt_d;
      tmo_err_q  <= tmo_err_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.o_stdp_run    = (state_q == S_RUN);
  assign bus.o_stdp_sub    = sub_q;
  assign bus.o_post_spike  = post_q;
  assign bus.o_pre_spike   = pre_q;
  assign bus.o_trace_hold  = (state_q == S_RUN) || (state_q == S_WAIT);
  assign bus.o_busy        = (state_q != S_IDLE);
  assign bus.o_step_done   = (state_q == S_FINISH);
  assign bus.o_run_cnt     = run_cnt_q;
  assign bus.o_skip_cnt    = skip_cnt_q;
  assign bus.o_timeout_err = tmo_err_q;
  assign bus.o_overrun     = overrun_q;

endmodule
